// File: rtl/aes_round_ctrl.sv
// Control sequencer for an iterative AES-128 encryption core: one LOAD cycle, NR-1 full rounds,
// one final round without MixColumns, then a DONE state that holds the ciphertext until taken.
module aes_round_ctrl #(
  parameter int unsigned NR  = 10,
  parameter int unsigned CW  = 4,
  parameter int unsigned BCW = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  output logic           out_valid,
  input  logic           out_ready,
  input  logic           flush,
  output logic           ld_init,
  output logic           ld_round,
  output logic           skip_mix,
  output logic [CW-1:0]  round_cnt,
  output logic [7:0]     rcon,
  output logic           busy,
  output logic [BCW-1:0] blk_cnt
);

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StRound,
    StFinal,
    StDone
  } state_e;

  state_e         state_q, state_d;
  logic [CW-1:0]  round_cnt_q, round_cnt_d;
  logic [7:0]     rcon_q, rcon_d;
  logic [BCW-1:0] blk_cnt_q, blk_cnt_d;

  // Multiply by x in GF(2^8) modulo the AES polynomial.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  always_comb begin
    state_d     = state_q;
    round_cnt_d = round_cnt_q;
    rcon_d      = rcon_q;
    blk_cnt_d   = blk_cnt_q;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    ld_init     = 1'b0;
    ld_round    = 1'b0;
    skip_mix    = 1'b0;
    busy        = 1'b0;

    unique case (state_q)
      StIdle: begin
        in_ready    = 1'b1;
        round_cnt_d = '0;
        rcon_d      = 8'h00;
        if (in_valid) state_d = StLoad;
      end
      StLoad: begin
        ld_init     = 1'b1;
        busy        = 1'b1;
        state_d     = StRound;
        round_cnt_d = CW'(1);
        rcon_d      = 8'h01;
      end
      StRound: begin
        ld_round    = 1'b1;
        busy        = 1'b1;
        round_cnt_d = round_cnt_q + CW'(1);
        rcon_d      = xtime(rcon_q);
        if (round_cnt_q == CW'(NR - 1)) state_d = StFinal;
      end
      StFinal: begin
        ld_round  = 1'b1;
        skip_mix  = 1'b1;
        busy      = 1'b1;
        state_d   = StDone;
        rcon_d    = 8'h00;
        blk_cnt_d = blk_cnt_q + BCW'(1);
      end
      StDone: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d     = StIdle;
          round_cnt_d = '0;
        end
      end
      default: begin
        state_d     = StIdle;
        round_cnt_d = '0;
        rcon_d      = 8'h00;
      end
    endcase

    // Abort wins over everything, including the block-count update in FINAL.
    if (flush) begin
      state_d     = StIdle;
      round_cnt_d = '0;
      rcon_d      = 8'h00;
      blk_cnt_d   = blk_cnt_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      round_cnt_q <= '0;
      rcon_q      <= 8'h00;
      blk_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      round_cnt_q <= round_cnt_d;
      rcon_q      <= rcon_d;
      blk_cnt_q   <= blk_cnt_d;
    end
  end

  // rcon_q is kept at zero outside ROUND/FINAL, so it can be driven out directly.
  assign round_cnt = round_cnt_q;
  assign rcon      = rcon_q;
  assign blk_cnt   = blk_cnt_q;

endmodule
